// File: rtl/note_player_if.sv
// Song note handshake between the song reader (master) and the note player (slave).
// A note transfers on any rising edge where new_note and player_ready are both high.
interface note_player_if;
  logic       new_note;
  logic [5:0] note;
  logic [5:0] duration;
  logic       player_ready;

  modport master (output new_note, note, duration, input player_ready);
  modport slave  (input new_note, note, duration, output player_ready);
endinterface

// File: rtl/note_player.sv
// Note player: one-deep pending slot feeding an IDLE/LOAD/PLAY sequencer that times
// each note in beats and presents the sounding note to the tone generator.
module note_player (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              beat,
  note_player_if.slave      song,
  output logic [5:0]        note_out,
  output logic              sounding,
  output logic              load_new_note,
  output logic              note_done,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2
  } state_t;

  state_t     state, state_n;
  logic       pend_valid;
  logic [5:0] pend_note;
  logic [5:0] pend_dur;
  logic [5:0] cur_note;
  logic [5:0] beats_left;
  logic       accept;
  logic       beat_tick;

  assign accept    = song.new_note & ~pend_valid;
  assign beat_tick = play & beat;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      pend_valid    <= 1'b0;
      pend_note     <= '0;
      pend_dur      <= '0;
      cur_note      <= '0;
      beats_left    <= '0;
      load_new_note <= 1'b0;
    end else begin
      state         <= state_n;
      load_new_note <= (state == LOAD) && (pend_dur != 6'd0);
      // The slot is never full and empty at once, so accept and LOAD cannot collide.
      if (accept) begin
        pend_valid <= 1'b1;
        pend_note  <= song.note;
        pend_dur   <= song.duration;
      end else if (state == LOAD) begin
        pend_valid <= 1'b0;
      end
      if (state == LOAD && pend_dur != 6'd0) begin
        cur_note   <= pend_note;
        beats_left <= pend_dur;
      end else if (state == PLAY && beat_tick && beats_left != 6'd0) begin
        beats_left <= beats_left - 6'd1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    note_done = 1'b0;
    unique case (state)
      IDLE: if (pend_valid) state_n = LOAD;
      LOAD: begin
        if (pend_dur == 6'd0) begin
          note_done = 1'b1;
          state_n   = IDLE;
        end else begin
          state_n   = PLAY;
        end
      end
      PLAY: begin
        if (beat_tick && beats_left == 6'd1) begin
          note_done = 1'b1;
          state_n   = pend_valid ? LOAD : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign song.player_ready = ~pend_valid;
  assign note_out          = (state == PLAY) ? cur_note : 6'd0;
  assign sounding          = (state == PLAY) && play && (cur_note != 6'd0);
  assign busy              = (state != IDLE) || pend_valid;
  assign state_dbg         = state;

endmodule

// File: doc/note_player.md
# note_player

Consumer end of the song note handshake. Accepts notes offered on `new_note`/`note`/`duration` under `player_ready` flow control, holds one note in a pending slot while the current note sounds, and counts `beat` pulses to time each note. It presents the sounding note to the synthesis path and reports note boundaries. It sits between the song reader and the tone generator.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high; clears all state on the next rising edge
- `play`  in  1  1 = beats advance the note timer; 0 = paused
- `beat`  in  1  one-cycle beat strobe
- `new_note`  in  1  offer valid; a note is accepted when `new_note & player_ready`
- `note`  in  6  note code; 0 = rest
- `duration`  in  6  length in beats; 0 = zero-length note
- `player_ready`  out  1  pending slot empty; reset value 1
- `note_out`  out  6  current note code; 0 when not in PLAY; reset value 0
- `sounding`  out  1  `(state==PLAY) & play & (note_out!=0)`; reset value 0
- `load_new_note`  out  1  one-cycle pulse in the first PLAY cycle of each note; reset value 0
- `note_done`  out  1  one-cycle pulse when a note completes; reset value 0
- `busy`  out  1  state != IDLE or pending slot valid; reset value 0

## Operation
- Pending slot: `pend_valid`, `pend_note[5:0]`, `pend_dur[5:0]`.
  - `player_ready = ~pend_valid`.
  - On accept, the slot captures `note`/`duration` and sets `pend_valid`.
  - `new_note` while `player_ready=0` is ignored; no overwrite.
- Current note registers: `cur_note[5:0]`, `beats_left[5:0]`.
- State machine (3 states, reset to IDLE):
  - IDLE: `pend_valid` -> LOAD; otherwise stay.
  - LOAD (exactly 1 cycle):
    - Clears `pend_valid`.
    - If `pend_dur==0`: `note_done=1` this cycle, `cur_note` unchanged, next state IDLE.
    - Otherwise: `cur_note<=pend_note`, `beats_left<=pend_dur`, next state PLAY.
  - PLAY:
    - `play & beat`: `beats_left` decrements.
    - `play & beat & beats_left==1`: `note_done=1` this cycle; next state LOAD if `pend_valid`, else IDLE.
    - `play=0`: beats ignored, `beats_left` frozen, state held.
- Accepts are allowed in every state, including while paused. An accept in a LOAD cycle is impossible because `pend_valid=1` there.
- `load_new_note` is a register set on the LOAD->PLAY transition; it pulses for exactly one cycle.
- `note_out` = `cur_note` when state==PLAY, else 0.
- Rests (`note=0`) are timed normally; `sounding` stays 0 throughout.
- `beats_left` never wraps: decrement occurs only from values >= 1.

## Timing
- Accept to sound: accept in cycle 0 -> `pend_valid`/`player_ready=0` in cycle 1 (IDLE) -> LOAD in cycle 2 -> PLAY in cycle 3, with `note_out` valid and `load_new_note=1`. Minimum latency is 3 cycles.
- `player_ready` returns to 1 in the cycle after LOAD, so the next note can be accepted while the current one plays.
- Back-to-back notes: a done cycle in PLAY is followed by LOAD, then PLAY of the next note. `note_out` reads 0 for exactly the one LOAD cycle (articulation gap).
- Note of duration D with `play` held high sounds from the first PLAY cycle through the cycle of the D-th beat.
- Zero-length note: LOAD cycle with `note_done=1`, no `load_new_note`, `note_out` stays 0.
- A beat that arrives in the LOAD cycle or the IDLE cycle is not counted.
- Reset mid-note: on the next edge, state=IDLE, `pend_valid=0`, `cur_note=0`, `beats_left=0`, and all outputs return to their reset values. A `new_note` coincident with `reset` is dropped.
- `play` falling in the same cycle as the last beat: the beat is not counted (`play` is sampled with `beat`).

## Test plan
- Reset, then accept `note=5, duration=2`, beats every 8 cycles with `play=1` -> `load_new_note` 3 cycles after accept; `note_out=5`, `sounding=1` until the 2nd beat; `note_done` pulses on that beat; then IDLE with `note_out=0`.
- Offer two notes back-to-back (`7/1`, then `9/3`) -> the second is accepted the cycle after LOAD of the first. `note_out` sequence: 7, one cycle of 0, then 9. Exactly two `load_new_note` pulses.
- While `player_ready=0`, hold `new_note=1` with a third note -> not captured until the slot frees; pending contents are unchanged.
- Note `4/3`, drop `play` after 1 beat for 20 cycles while issuing beats -> `beats_left` holds at 2 and `sounding=0`. On resume, completes after 2 more beats.
- `duration=0` note, and a rest `0/2` -> zero-length note produces `note_done` in LOAD with no `load_new_note`; the rest lasts 2 beats with `sounding=0`.
- Assert `reset` mid-PLAY with a pending note -> next cycle all outputs are at reset values, `player_ready=1`, and no `note_done` is emitted.
